// File: rtl/imu_spi_seq.sv
// imu_spi_seq: SPI sequencer for the inertial sensor.
// Sits between the inertial integrator and an external spi_master.
// After a power-up wait it replays a table of init writes. Each
// data-ready interrupt then triggers a burst of 16-bit channel reads,
// and the channels are published together with a vld pulse. It also
// handles transaction timeouts, software re-init requests and
// interrupt overrun.
//
// state | meaning
// ------+---------------------------------------------------------
// PWRUP | free-running wait after reset before touching the sensor
// INIT  | issuing init table writes, idx = entry in flight
// WAIT  | idle, waiting for synchronised INT or a pending reinit
// READ  | channel read burst, idx = byte transaction in flight
//
// Every output is registered. A decision taken in the cycle an event is
// seen (done, INT, timeout) shows up on wrt/cmd/vld/err/ovr one cycle
// later.

module imu_spi_seq #(
    parameter int                     NUM_INIT  = 4,
    parameter logic [16*NUM_INIT-1:0] INIT_CMDS = {16'h1460, 16'h1150, 16'h1053, 16'h0D02},
    parameter int                     NUM_CH    = 4,
    parameter logic [8*NUM_CH-1:0]    CH_ADDR   = {8'h2C, 8'h2A, 8'h26, 8'h24},
    parameter int                     PWRUP_W   = 16,
    parameter int                     TO_W      = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   reinit,
    input  logic                   INT,
    output logic                   wrt,
    output logic [15:0]            cmd,
    input  logic                   done,
    input  logic [7:0]             rd_data,
    output logic [NUM_CH*16-1:0]   data,
    output logic                   vld,
    output logic                   err,
    output logic                   ovr
);

    localparam int NUM_RD  = 2 * NUM_CH;
    localparam int IDX_MAX = (NUM_INIT > NUM_RD) ? NUM_INIT : NUM_RD;
    localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

    typedef enum logic [1:0] {
        S_PWRUP = 2'd0,
        S_INIT  = 2'd1,
        S_WAIT  = 2'd2,
        S_READ  = 2'd3
    } state_t;

    state_t               state, state_nxt;

    logic [PWRUP_W-1:0]   pwr_cnt, pwr_nxt;
    logic [TO_W-1:0]      to_cnt, to_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic [NUM_CH*16-1:0] shadow, shadow_nxt;
    logic                 ovr_flag, ovr_flag_nxt;
    logic                 pend, pend_nxt;

    logic                 int_s1, int_s2, int_s3;
    logic                 int_rise;

    logic                 wrt_nxt;
    logic [15:0]          cmd_nxt;
    logic [NUM_CH*16-1:0] data_nxt;
    logic                 vld_nxt, err_nxt, ovr_nxt;

    // decisions shared between next-state and output logic
    logic                 restart;    // back to INIT entry 0, issue it now
    logic                 step;       // issue the next entry of the current table
    logic                 start_rd;   // begin a read burst with channel 0 low byte
    logic                 finish;     // final read byte arrived, publish shadow
    logic                 timeout;

    logic                 pwr_full, to_full, last_init, last_rd;

    // Init table entry i.
    function automatic logic [15:0] init_cmd(input logic [IDX_W-1:0] i);
        return INIT_CMDS[16*int'(i) +: 16];
    endfunction

    // Read command for byte transaction t. Even t reads the channel's low
    // byte and odd t its high byte at address+1. Only the low 7 address
    // bits reach the wire, so the +1 is done in 7 bits.
    function automatic logic [15:0] rd_cmd(input logic [IDX_W-1:0] t);
        logic [6:0] a7;
        a7 = CH_ADDR[8*(int'(t) >> 1) +: 7] + {6'd0, t[0]};
        return {1'b1, a7, 8'h00};
    endfunction

    assign pwr_full  = &pwr_cnt;
    assign to_full   = &to_cnt;
    assign last_init = (idx == IDX_W'(NUM_INIT - 1));
    assign last_rd   = (idx == IDX_W'(NUM_RD - 1));
    assign int_rise  = int_s2 & ~int_s3;

    // Two-flop INT synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_s1 <= 1'b0;
            int_s2 <= 1'b0;
            int_s3 <= 1'b0;
        end else begin
            int_s1 <= INT;
            int_s2 <= int_s1;
            int_s3 <= int_s2;
        end
    end

    // State, counters, shadow and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_PWRUP;
            pwr_cnt  <= '0;
            to_cnt   <= '0;
            idx      <= '0;
            shadow   <= '0;
            ovr_flag <= 1'b0;
            pend     <= 1'b0;
            wrt      <= 1'b0;
            cmd      <= '0;
            data     <= '0;
            vld      <= 1'b0;
            err      <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            state    <= state_nxt;
            pwr_cnt  <= pwr_nxt;
            to_cnt   <= to_nxt;
            idx      <= idx_nxt;
            shadow   <= shadow_nxt;
            ovr_flag <= ovr_flag_nxt;
            pend     <= pend_nxt;
            wrt      <= wrt_nxt;
            cmd      <= cmd_nxt;
            data     <= data_nxt;
            vld      <= vld_nxt;
            err      <= err_nxt;
            ovr      <= ovr_nxt;
        end
    end

    // Next-state decisions. done is checked before the timeout so a
    // completion that lands on the last count still counts.
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        step      = 1'b0;
        start_rd  = 1'b0;
        finish    = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_PWRUP: begin
                if (pwr_full) begin
                    restart = 1'b1;
                end
            end
            S_INIT: begin
                if (done) begin
                    if (pend) begin
                        restart = 1'b1;
                    end else if (last_init) begin
                        state_nxt = S_WAIT;
                    end else begin
                        step = 1'b1;
                    end
                end else if (to_full) begin
                    timeout = 1'b1;
                    restart = 1'b1;
                end
            end
            S_WAIT: begin
                if (pend) begin
                    restart = 1'b1;
                end else if (int_s2) begin
                    start_rd  = 1'b1;
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (done) begin
                    if (last_rd) begin
                        // publish even when a reinit is pending
                        finish    = 1'b1;
                        restart   = pend;
                        state_nxt = S_WAIT;
                    end else if (pend) begin
                        restart = 1'b1;
                    end else begin
                        step = 1'b1;
                    end
                end else if (to_full) begin
                    timeout = 1'b1;
                    restart = 1'b1;
                end
            end
            default: begin
                restart = 1'b1;
            end
        endcase
        if (restart) begin
            state_nxt = S_INIT;
        end
    end

    // Next values for counters, shadow and outputs.
    always_comb begin
        pwr_nxt      = pwr_cnt;
        to_nxt       = to_cnt;
        idx_nxt      = idx;
        shadow_nxt   = shadow;
        ovr_flag_nxt = ovr_flag;
        pend_nxt     = pend | reinit;
        wrt_nxt      = 1'b0;
        cmd_nxt      = cmd;
        data_nxt     = data;
        vld_nxt      = 1'b0;
        err_nxt      = timeout;
        ovr_nxt      = 1'b0;

        if (state == S_PWRUP) begin
            pwr_nxt = pwr_cnt + 1'b1;
        end

        if (state == S_INIT || state == S_READ) begin
            to_nxt = to_cnt + 1'b1;
        end

        if (state == S_READ) begin
            if (done) begin
                shadow_nxt[8*int'(idx) +: 8] = rd_data;
            end
            if (int_rise) begin
                ovr_flag_nxt = 1'b1;
            end
        end

        if (finish) begin
            data_nxt = shadow_nxt;
            vld_nxt  = 1'b1;
            ovr_nxt  = ovr_flag_nxt;
        end

        if (step) begin
            idx_nxt = idx + 1'b1;
            wrt_nxt = 1'b1;
            cmd_nxt = (state == S_INIT) ? init_cmd(idx + 1'b1) : rd_cmd(idx + 1'b1);
            to_nxt  = '0;
        end

        if (start_rd) begin
            idx_nxt      = '0;
            wrt_nxt      = 1'b1;
            cmd_nxt      = rd_cmd('0);
            to_nxt       = '0;
            ovr_flag_nxt = 1'b0;
        end

        // Init restarts from entry 0. A reinit request is already satisfied
        // by this, including one raised during power-up.
        if (restart) begin
            idx_nxt    = '0;
            wrt_nxt    = 1'b1;
            cmd_nxt    = init_cmd('0);
            to_nxt     = '0;
            shadow_nxt = '0;
            pend_nxt   = 1'b0;
        end
    end

endmodule

// File: tb/tb_imu_spi_seq.sv
// Testbench for imu_spi_seq with PWRUP_W=4 and TO_W=6.
// The spi_master model answers every wrt with done 20 cycles later.
// Its rd_data bytes are either queued in advance or random.
// Expected commands and channel data come from the bench's own register
// tables and the bytes the master handed out.

module tb_imu_spi_seq;

    logic        clk;
    logic        rst_n;
    logic        reinit;
    logic        INT;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [7:0]  rd_data;
    logic [63:0] data;
    logic        vld;
    logic        err;
    logic        ovr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] init_tbl [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    logic [7:0]  ch_addr  [4] = '{8'h24, 8'h26, 8'h2A, 8'h2C};

    logic [15:0] wrt_q[$];
    int          wrt_cyc_q[$];
    logic [63:0] vld_q[$];
    logic        vld_ovr_q[$];
    int          vld_cyc_q[$];
    int          err_cyc_q[$];
    logic [7:0]  rd_byte_q[$];
    logic [7:0]  serve_q[$];

    int          drop_idx  = -1;
    int          rd_seen   = 0;
    int          ovr_stray = 0;
    logic [63:0] exp_data  = '0;

    imu_spi_seq #(
        .PWRUP_W (4),
        .TO_W    (6)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .reinit  (reinit),
        .INT     (INT),
        .wrt     (wrt),
        .cmd     (cmd),
        .done    (done),
        .rd_data (rd_data),
        .data    (data),
        .vld     (vld),
        .err     (err),
        .ovr     (ovr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // spi_master model and output monitor, sampled mid-cycle
    initial begin
        logic       busy;
        logic       cur_is_rd;
        logic [7:0] cur_byte;
        int         cd;
        busy      = 1'b0;
        cur_is_rd = 1'b0;
        cur_byte  = '0;
        cd        = 0;
        done      = 1'b0;
        rd_data   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done = 1'b0;
                busy = 1'b0;
            end else begin
                done = 1'b0;
                if (busy) begin
                    cd--;
                    if (cd == 0) begin
                        busy    = 1'b0;
                        done    = 1'b1;
                        rd_data = cur_byte;
                        if (cur_is_rd) rd_byte_q.push_back(cur_byte);
                    end
                end
                if (wrt) begin
                    wrt_q.push_back(cmd);
                    wrt_cyc_q.push_back(cyc);
                    cur_is_rd = cmd[15];
                    if (cmd[15] && serve_q.size() > 0) cur_byte = serve_q.pop_front();
                    else cur_byte = 8'($urandom);
                    cd   = 20;
                    busy = 1'b1;
                    if (cmd[15]) begin
                        if (rd_seen == drop_idx) busy = 1'b0;
                        rd_seen++;
                    end
                end
                if (vld) begin
                    vld_q.push_back(data);
                    vld_ovr_q.push_back(ovr);
                    vld_cyc_q.push_back(cyc);
                end
                if (err) err_cyc_q.push_back(cyc);
                if (ovr && !vld) ovr_stray++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        wrt_q.delete();
        wrt_cyc_q.delete();
        vld_q.delete();
        vld_ovr_q.delete();
        vld_cyc_q.delete();
        err_cyc_q.delete();
        rd_byte_q.delete();
        rd_seen = 0;
    endtask

    task automatic wait_wrt(input int n, input int budget, input string tag);
        int i = 0;
        while (wrt_q.size() < n && i < budget) begin
            tick();
            i++;
        end
        chk(tag, 64'(wrt_q.size() >= n), 64'd1);
    endtask

    task automatic wait_vld(input int n, input int budget, input string tag);
        int i = 0;
        while (vld_q.size() < n && i < budget) begin
            tick();
            i++;
        end
        chk(tag, 64'(vld_q.size() >= n), 64'd1);
    endtask

    task automatic wait_err(input int budget, input string tag);
        int i = 0;
        while (err_cyc_q.size() < 1 && i < budget) begin
            tick();
            i++;
        end
        chk(tag, 64'(err_cyc_q.size() >= 1), 64'd1);
    endtask

    task automatic pulse_int(input int n);
        INT = 1'b1;
        repeat (n) tick();
        INT = 1'b0;
    endtask

    // Read j of a burst: channel j/2, odd j is the high byte at addr+1.
    function automatic logic [15:0] exp_rd(input int j);
        logic [7:0] a;
        a = ch_addr[j / 2] + 8'(j % 2);
        return 16'h8000 + 16'(a % 8'd128) * 16'd256;
    endfunction

    // Data word of burst b: bytes in arrival order, ch0 low first.
    function automatic logic [63:0] exp_burst(input int b);
        logic [63:0] d;
        d = '0;
        for (int j = 0; j < 8; j++) d[8*j +: 8] = rd_byte_q[8*b + j];
        return d;
    endfunction

    task automatic check_init(input int base, input string tag);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_cmd%0d", tag, i), 64'(wrt_q[base + i]), 64'(init_tbl[i]));
        for (int i = 1; i < 4; i++)
            chk($sformatf("%s_gap%0d", tag, i), 64'(wrt_cyc_q[base + i] - wrt_cyc_q[base + i - 1]), 64'd21);
    endtask

    task automatic check_burst(input int base, input int b, input string tag);
        for (int j = 0; j < 8; j++)
            chk($sformatf("%s_cmd%0d", tag, j), 64'(wrt_q[base + j]), 64'(exp_rd(j)));
        chk({tag, "_data"}, vld_q[b], exp_burst(b));
        chk({tag, "_vld_time"}, 64'(vld_cyc_q[b] - wrt_cyc_q[base + 7]), 64'd21);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_wrt"}, 64'(wrt), 64'd0);
        chk({tag, "_cmd"}, 64'(cmd), 64'd0);
        chk({tag, "_data"}, data, 64'd0);
        chk({tag, "_vld"}, 64'(vld), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_ovr"}, 64'(ovr), 64'd0);
    endtask

    initial begin
        int r;
        int c;
        rst_n  = 1'b0;
        INT    = 1'b0;
        reinit = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");

        // power-up: counter reads all-ones after 15 edges, wrt registers on the next
        r = cyc;
        rst_n = 1'b1;
        wait_wrt(4, 200, "init_wait");
        repeat (25) tick();
        chk("pwrup_first_wrt", 64'(wrt_cyc_q[0] - r), 64'd16);
        check_init(0, "init");
        chk("init_no_vld", 64'(vld_q.size()), 64'd0);
        chk("init_no_err", 64'(err_cyc_q.size()), 64'd0);

        // single burst with known bytes
        clear_logs();
        serve_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        c = cyc;
        pulse_int(3);
        wait_vld(1, 400, "burst1_wait");
        repeat (3) tick();
        chk("int_to_wrt", 64'(wrt_cyc_q[0] - c), 64'd3);
        check_burst(0, 0, "burst1");
        chk("burst1_const", data, 64'h8877_6655_4433_2211);
        chk("burst1_ovr", 64'(vld_ovr_q[0]), 64'd0);
        chk("burst1_vld_count", 64'(vld_q.size()), 64'd1);
        exp_data = 64'h8877_6655_4433_2211;

        // random bursts
        for (int k = 0; k < 4; k++) begin
            clear_logs();
            repeat ($urandom_range(2, 10)) tick();
            pulse_int($urandom_range(1, 5));
            wait_vld(1, 400, $sformatf("rnd%0d_wait", k));
            repeat (3) tick();
            check_burst(0, 0, $sformatf("rnd%0d", k));
            chk($sformatf("rnd%0d_ovr", k), 64'(vld_ovr_q[0]), 64'd0);
            exp_data = exp_burst(0);
        end

        // overrun plus level retrigger
        clear_logs();
        INT = 1'b1;
        wait_wrt(3, 200, "ovr_mid_wait");
        INT = 1'b0;
        repeat (3) tick();
        INT = 1'b1;
        wait_vld(1, 400, "ovr_vld1_wait");
        repeat (2) tick();
        INT = 1'b0;
        wait_vld(2, 400, "ovr_vld2_wait");
        repeat (3) tick();
        chk("ovr_flagged", 64'(vld_ovr_q[0]), 64'd1);
        chk("retrigger_time", 64'(wrt_cyc_q[8] - vld_cyc_q[0]), 64'd1);
        check_burst(0, 0, "ovr_b0");
        check_burst(8, 1, "ovr_b1");
        chk("ovr_b1_clear", 64'(vld_ovr_q[1]), 64'd0);
        chk("ovr_vld_count", 64'(vld_q.size()), 64'd2);
        exp_data = exp_burst(1);

        // timeout on the third read: counter is 0 in the wrt cycle, all-ones
        // 63 cycles later, err registered one cycle after that
        clear_logs();
        drop_idx = 2;
        pulse_int(2);
        wait_err(400, "to_err_wait");
        wait_wrt(7, 300, "to_init_wait");
        repeat (25) tick();
        drop_idx = -1;
        chk("to_err_time", 64'(err_cyc_q[0] - wrt_cyc_q[2]), 64'd64);
        chk("to_reissue_time", 64'(wrt_cyc_q[3] - err_cyc_q[0]), 64'd0);
        check_init(3, "to_init");
        chk("to_no_vld", 64'(vld_q.size()), 64'd0);
        chk("to_err_count", 64'(err_cyc_q.size()), 64'd1);
        chk("to_data_hold", data, exp_data);

        // recovery burst
        clear_logs();
        pulse_int(2);
        wait_vld(1, 400, "post_to_wait");
        repeat (3) tick();
        check_burst(0, 0, "post_to");
        exp_data = exp_burst(0);

        // reinit during the second read
        clear_logs();
        pulse_int(2);
        wait_wrt(2, 200, "ri_rd2_wait");
        repeat (5) tick();
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        wait_wrt(6, 300, "ri_init_wait");
        repeat (25) tick();
        chk("ri_rd0", 64'(wrt_q[0]), 64'(exp_rd(0)));
        chk("ri_rd1", 64'(wrt_q[1]), 64'(exp_rd(1)));
        chk("ri_rd1_completed", 64'(wrt_cyc_q[2] - wrt_cyc_q[1]), 64'd21);
        check_init(2, "ri_init");
        chk("ri_no_vld", 64'(vld_q.size()), 64'd0);
        chk("ri_data_hold", data, exp_data);

        // reinit while idle
        clear_logs();
        c = cyc;
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        wait_wrt(4, 200, "riw_wait");
        repeat (25) tick();
        chk("riw_latency", 64'(wrt_cyc_q[0] - c), 64'd2);
        check_init(0, "riw_init");

        // asynchronous reset mid-burst, reinit during power-up is discarded
        clear_logs();
        pulse_int(2);
        wait_wrt(3, 200, "ar_wait");
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        tick();
        tick();
        clear_logs();
        r = cyc;
        rst_n = 1'b1;
        repeat (5) tick();
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        wait_wrt(4, 300, "ar_init_wait");
        repeat (25) tick();
        chk("ar_first_wrt", 64'(wrt_cyc_q[0] - r), 64'd16);
        check_init(0, "ar_init");
        chk("ar_wrt_count", 64'(wrt_q.size()), 64'd4);
        chk("ar_no_vld", 64'(vld_q.size()), 64'd0);

        // burst after reset
        clear_logs();
        pulse_int(2);
        wait_vld(1, 400, "final_wait");
        repeat (3) tick();
        check_burst(0, 0, "final");

        chk("ovr_without_vld", 64'(ovr_stray), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: got timeout, expected end of test");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
